can_tx_frame_sequencer: RTL and testbench
=========================================

Name: can_tx_frame_sequencer

Overview:
- Sequences one CAN 2.0A base-format data or remote frame, one bit per sample point, into the bit_stuffing block.
- Drives bit_stuffing's per-field handshake inputs: sof_transmitting, the active-low *_complete flags, field bits and crc_bit_counter.
- Holds the current bit whenever the stuffer inserts a stuff bit.
- Appends the unstuffed tail (CRC delimiter, ACK slot, ACK delimiter, EOF) and reports completion to the host.

Parameters:
- ID_W, 11, identifier width (base format).
- CRC_W, 15, CRC field width.
- TAIL_BITS, 10, recessive tail length: CRC delim + ACK slot + ACK delim + 7 EOF.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- enable  in  1  0 freezes all state and outputs
- sample_point  in  1  single-cycle bit-time strobe
- tx_request  in  1  host frame request; level, sampled only in IDLE
- tx_id  in  11  identifier, MSB first
- tx_rtr  in  1  1 = remote frame
- tx_dlc  in  4  data length code
- tx_data  in  64  payload; byte0 = [63:56], bit 63 sent first
- crc_value  in  15  CRC from CRC unit, valid by the first CRC bit
- stuff_bit_inserted  in  1  from bit_stuffing; hold current bit this sample point
- tx_accept  out  1  1-cycle pulse when a request is latched
- tx_busy  out  1  high from SOF through the last tail bit
- tx_done  out  1  1-cycle pulse after the last tail bit
- sof_transmitting  out  1  high during SOF
- sof_bit  out  1  always 0 (dominant)
- id_complete  out  1  0 while the ID field is active
- bit_id  out  1  current ID bit
- rtr_complete  out  1  0 while RTR is active
- rtr_bit  out  1  latched tx_rtr
- control_complete  out  1  0 while the control field is active
- control_bit  out  1  IDE, r0, DLC[3:0]
- data_complete  out  1  0 while the data field is active
- data_bit  out  1  current data bit
- crc_complete  out  1  0 while the CRC field is active
- crc_bit  out  1  crc_value[14 - crc_bit_counter]
- crc_bit_counter  out  4  index 0..14 within the CRC field
- eof_complete  out  1  1 during the tail; 0 otherwise

Behaviour:
- Reset values: all *_complete = 1, eof_complete = 0, sof_transmitting = 0, every *_bit = 0, crc_bit_counter = 0, tx_busy/tx_accept/tx_done = 0, state = IDLE. Reset mid-frame aborts the frame silently (no tx_done).
- Advance condition: adv = enable & sample_point & !stuff_bit_inserted. The bit counter and state change only on adv. With stuff_bit_inserted = 1 at a sample point, all outputs hold, so that bit is re-presented at the next sample point.
- FSM transitions (bitcnt = per-field counter, reset on each field entry):
  - IDLE: when enable & tx_request, latch id/rtr/dlc/data, pulse tx_accept, go to SOF (no sample point needed).
  - SOF: 1 bit, then ID.
  - ID: 11 bits, then RTR.
  - RTR: 1 bit, then CTRL.
  - CTRL: 6 bits (0, 0, dlc[3], dlc[2], dlc[1], dlc[0]), then DATA if nbits > 0, else CRC.
  - DATA: nbits, then CRC.
  - CRC: 15 bits, then TAIL.
  - TAIL: 10 bits, then DONE.
  - DONE: pulse tx_done for 1 cycle, then IDLE.
- Data length: nbits = 0 when rtr = 1; otherwise 8 × min(dlc, 8). DLC 9..15 clamps to 64 bits but DLC is still transmitted as given.
- Field outputs: a field's *_complete goes low on the cycle its state is entered and returns high on the cycle the next state is entered. Only one field is active at a time.
- crc_bit_counter increments on each adv in CRC, holds 14 through TAIL, and clears on IDLE.
- tx_request held high after DONE starts a new frame with 1 idle cycle between frames (no interframe space; the host enforces it).
- enable low mid-frame freezes the frame; resuming continues from the same bit.

Decomposition:
- can_pkg: state enum (IDLE, SOF, ID, RTR, CTRL, DATA, CRC, TAIL, DONE), field width constants (ID_W, CTRL_W = 6, CRC_W, TAIL_BITS, MAX_DATA_BITS = 64), dominant/recessive constants.
- One sub-module: can_field_shifter, a loadable MSB-first shift register with bit counter and a "last" flag, instanced for ID/CTRL/DATA.

Test Plan:
- Data frame, id = 0x7FF, dlc = 1, data byte 0xFF, stuff_bit_inserted tied 0 -> id_complete low for exactly 11 sample points; data_complete low for 8; total 1 + 11 + 1 + 6 + 8 + 15 + 10 = 52 sample points before tx_done.
- Remote frame, rtr = 1, dlc = 8 -> data_complete never goes low; CRC field directly follows CTRL; 44 sample points.
- Stuff stall: pulse stuff_bit_inserted at the 6th ID sample point -> bit_id identical across that and the next sample point; ID field lasts 12 sample points; tx_done 1 sample point late.
- dlc = 12, data 0xA5A5... -> exactly 64 data bits transmitted; control_bit sequence 0, 0, 1, 1, 0, 0.
- crc_value = 0x4A3C -> crc_bit sequence 100101000111100 with crc_bit_counter 0..14; eof_complete high for 10 sample points.
- Reset asserted in the DATA field, then released -> all outputs return to reset values; no tx_done; next request starts cleanly at SOF.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN frame constants, FSM state encoding and data-length helper
// used by the transmit frame sequencer.
package can_pkg;

    localparam int ID_W          = 11;
    localparam int CTRL_W        = 6;
    localparam int CRC_W         = 15;
    localparam int TAIL_BITS     = 10;
    localparam int MAX_DATA_BITS = 64;

    localparam logic DOMINANT  = 1'b0;
    localparam logic RECESSIVE = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        SOF,
        ID,
        RTR,
        CTRL,
        DATA,
        CRC,
        TAIL,
        DONE
    } can_state_e;

    // Remote frames carry no payload; DLC values above 8 still mean 8 bytes.
    function automatic logic [6:0] data_bit_count(input logic rtr, input logic [3:0] dlc);
        if (rtr) begin
            return 7'd0;
        end
        if (dlc >= 4'd8) begin
            return 7'd64;
        end
        return {1'b0, dlc[2:0], 3'b000};
    endfunction

endpackage

// File: rtl/can_field_shifter.sv
// Loadable MSB-first shift register with a shift counter and a flag marking
// the last bit of a field of run-time length len_i.
module can_field_shifter #(
    parameter int W  = 11,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load_i,
    input  logic [W-1:0]  load_value_i,
    input  logic          shift_i,
    input  logic [CW-1:0] len_i,
    output logic          bit_o,
    output logic          last_o
);

    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = load_value_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_o  = shreg_q[W-1];
    assign last_o = (cnt_q == len_i - CW'(1));

endmodule

// File: rtl/can_tx_frame_sequencer.sv
// Walks one CAN 2.0A base frame through its fields, one bit per sample point,
// presenting each field to the bit stuffer and appending the recessive tail.
module can_tx_frame_sequencer #(
    parameter int ID_W      = can_pkg::ID_W,
    parameter int CRC_W     = can_pkg::CRC_W,
    parameter int TAIL_BITS = can_pkg::TAIL_BITS
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sample_point,
    input  logic             tx_request,
    input  logic [ID_W-1:0]  tx_id,
    input  logic             tx_rtr,
    input  logic [3:0]       tx_dlc,
    input  logic [63:0]      tx_data,
    input  logic [CRC_W-1:0] crc_value,
    input  logic             stuff_bit_inserted,
    output logic             tx_accept,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             sof_transmitting,
    output logic             sof_bit,
    output logic             id_complete,
    output logic             bit_id,
    output logic             rtr_complete,
    output logic             rtr_bit,
    output logic             control_complete,
    output logic             control_bit,
    output logic             data_complete,
    output logic             data_bit,
    output logic             crc_complete,
    output logic             crc_bit,
    output logic [3:0]       crc_bit_counter,
    output logic             eof_complete
);

    import can_pkg::*;

    localparam int ID_CW = $clog2(ID_W + 1);

    can_state_e state_q, state_d;
    logic       rtr_q, rtr_d;
    logic [3:0] dlc_q, dlc_d;
    logic [3:0] crc_cnt_q, crc_cnt_d;
    logic [3:0] tail_cnt_q, tail_cnt_d;
    logic       accept_q, accept_d;

    logic       adv, accept;
    logic [6:0] nbits;
    logic       id_bit, id_last, ctrl_bit, ctrl_last, dat_bit, dat_last;
    logic [3:0] crc_idx;

    // A stuff bit consumes the sample point, so the current bit is re-presented.
    assign adv    = enable & sample_point & ~stuff_bit_inserted;
    assign accept = (state_q == IDLE) & enable & tx_request;
    assign nbits  = data_bit_count(rtr_q, dlc_q);

    can_field_shifter #(.W(ID_W)) u_id_shifter (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_i       (accept),
        .load_value_i (tx_id),
        .shift_i      (adv && (state_q == ID)),
        .len_i        (ID_CW'(ID_W)),
        .bit_o        (id_bit),
        .last_o       (id_last)
    );

    can_field_shifter #(.W(CTRL_W)) u_ctrl_shifter (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_i       (accept),
        .load_value_i ({DOMINANT, DOMINANT, tx_dlc}),
        .shift_i      (adv && (state_q == CTRL)),
        .len_i        (3'(CTRL_W)),
        .bit_o        (ctrl_bit),
        .last_o       (ctrl_last)
    );

    can_field_shifter #(.W(MAX_DATA_BITS)) u_data_shifter (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_i       (accept),
        .load_value_i (tx_data),
        .shift_i      (adv && (state_q == DATA)),
        .len_i        (nbits),
        .bit_o        (dat_bit),
        .last_o       (dat_last)
    );

    always_comb begin
        state_d    = state_q;
        rtr_d      = rtr_q;
        dlc_d      = dlc_q;
        crc_cnt_d  = crc_cnt_q;
        tail_cnt_d = tail_cnt_q;
        accept_d   = accept;
        unique case (state_q)
            IDLE: begin
                crc_cnt_d  = '0;
                tail_cnt_d = '0;
                if (accept) begin
                    rtr_d   = tx_rtr;
                    dlc_d   = tx_dlc;
                    state_d = SOF;
                end
            end
            SOF:  if (adv) state_d = ID;
            ID:   if (adv && id_last) state_d = RTR;
            RTR:  if (adv) state_d = CTRL;
            CTRL: if (adv && ctrl_last) state_d = (nbits != 7'd0) ? DATA : CRC;
            DATA: if (adv && dat_last) state_d = CRC;
            CRC: begin
                // Counter parks on the last index so it reads 14 through the tail.
                if (adv) begin
                    if (crc_cnt_q == 4'(CRC_W - 1)) state_d = TAIL;
                    else crc_cnt_d = crc_cnt_q + 4'd1;
                end
            end
            TAIL: begin
                if (adv) begin
                    if (tail_cnt_q == 4'(TAIL_BITS - 1)) state_d = DONE;
                    else tail_cnt_d = tail_cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rtr_q      <= 1'b0;
            dlc_q      <= 4'd0;
            crc_cnt_q  <= 4'd0;
            tail_cnt_q <= 4'd0;
            accept_q   <= 1'b0;
        end else if (enable) begin
            state_q    <= state_d;
            rtr_q      <= rtr_d;
            dlc_q      <= dlc_d;
            crc_cnt_q  <= crc_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            accept_q   <= accept_d;
        end
    end

    assign crc_idx = 4'(CRC_W - 1) - crc_cnt_q;

    assign tx_accept        = accept_q;
    assign tx_busy          = (state_q != IDLE) && (state_q != DONE);
    assign tx_done          = (state_q == DONE);
    assign sof_transmitting = (state_q == SOF);
    assign sof_bit          = DOMINANT;
    assign id_complete      = (state_q != ID);
    assign bit_id           = (state_q == ID) & id_bit;
    assign rtr_complete     = (state_q != RTR);
    assign rtr_bit          = rtr_q;
    assign control_complete = (state_q != CTRL);
    assign control_bit      = (state_q == CTRL) & ctrl_bit;
    assign data_complete    = (state_q != DATA);
    assign data_bit         = (state_q == DATA) & dat_bit;
    assign crc_complete     = (state_q != CRC);
    assign crc_bit          = (state_q == CRC) & crc_value[crc_idx];
    assign crc_bit_counter  = crc_cnt_q;
    assign eof_complete     = (state_q == TAIL);

endmodule

// File: tb/tb_can_tx_frame_sequencer.sv
// Scoreboard bench: stimulus queues the expected per-sample-point field/bit
// records and frame lengths; a negedge monitor pops and compares them.
module tb_can_tx_frame_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        sample_point = 1'b0;
    logic        tx_request = 1'b0;
    logic [10:0] tx_id = '0;
    logic        tx_rtr = 1'b0;
    logic [3:0]  tx_dlc = '0;
    logic [63:0] tx_data = '0;
    logic [14:0] crc_value = '0;
    logic        stuff_bit_inserted = 1'b0;

    logic       tx_accept, tx_busy, tx_done, sof_transmitting, sof_bit;
    logic       id_complete, bit_id, rtr_complete, rtr_bit;
    logic       control_complete, control_bit, data_complete, data_bit;
    logic       crc_complete, crc_bit, eof_complete;
    logic [3:0] crc_bit_counter;

    can_tx_frame_sequencer dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .enable             (enable),
        .sample_point       (sample_point),
        .tx_request         (tx_request),
        .tx_id              (tx_id),
        .tx_rtr             (tx_rtr),
        .tx_dlc             (tx_dlc),
        .tx_data            (tx_data),
        .crc_value          (crc_value),
        .stuff_bit_inserted (stuff_bit_inserted),
        .tx_accept          (tx_accept),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done),
        .sof_transmitting   (sof_transmitting),
        .sof_bit            (sof_bit),
        .id_complete        (id_complete),
        .bit_id             (bit_id),
        .rtr_complete       (rtr_complete),
        .rtr_bit            (rtr_bit),
        .control_complete   (control_complete),
        .control_bit        (control_bit),
        .data_complete      (data_complete),
        .data_bit           (data_bit),
        .crc_complete       (crc_complete),
        .crc_bit            (crc_bit),
        .crc_bit_counter    (crc_bit_counter),
        .eof_complete       (eof_complete)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0] fld;
        logic       b;
        logic [3:0] cnt;
    } rec_t;

    localparam logic [6:0] F_SOF  = 7'b1000000;
    localparam logic [6:0] F_ID   = 7'b0100000;
    localparam logic [6:0] F_RTR  = 7'b0010000;
    localparam logic [6:0] F_CTRL = 7'b0001000;
    localparam logic [6:0] F_DATA = 7'b0000100;
    localparam logic [6:0] F_CRC  = 7'b0000010;
    localparam logic [6:0] F_TAIL = 7'b0000001;

    rec_t exp_q[$];
    int   done_q[$];
    int   tests = 0;
    int   fails = 0;
    int   sp_cnt = 0;
    int   done_cnt = 0;
    int   rec_idx = 0;

    // Monitor: one record per sample point while busy, one length per tx_done.
    always @(negedge clock) begin
        rec_t act;
        rec_t expv;
        int   expn;
        if (reset_n) begin
            if (tx_accept) sp_cnt = 0;
            if (enable && sample_point && tx_busy) begin
                act.fld = {sof_transmitting, ~id_complete, ~rtr_complete, ~control_complete,
                           ~data_complete, ~crc_complete, eof_complete};
                if (sof_transmitting)       act.b = sof_bit;
                else if (!id_complete)      act.b = bit_id;
                else if (!rtr_complete)     act.b = rtr_bit;
                else if (!control_complete) act.b = control_bit;
                else if (!data_complete)    act.b = data_bit;
                else if (!crc_complete)     act.b = crc_bit;
                else if (eof_complete)      act.b = 1'b1;
                else                        act.b = 1'b0;
                act.cnt = crc_bit_counter;
                sp_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sp_rec[%0d]: got fld=%b bit=%b cnt=%0d, required no sample point",
                             rec_idx, act.fld, act.b, act.cnt);
                end else begin
                    expv = exp_q.pop_front();
                    if (act !== expv) begin
                        fails++;
                        $display("FAIL sp_rec[%0d]: got fld=%b bit=%b cnt=%0d, required fld=%b bit=%b cnt=%0d",
                                 rec_idx, act.fld, act.b, act.cnt, expv.fld, expv.b, expv.cnt);
                    end
                end
                rec_idx++;
            end
            if (tx_done) begin
                done_cnt++;
                tests++;
                if (done_q.size() == 0) begin
                    fails++;
                    $display("FAIL frame_len: unexpected tx_done after %0d sample points", sp_cnt);
                end else begin
                    expn = done_q.pop_front();
                    if (sp_cnt != expn) begin
                        fails++;
                        $display("FAIL frame_len: got %0d sample points, required %0d", sp_cnt, expn);
                    end
                    $display("[TB] frame %0d done after %0d sample points (expected %0d)",
                             done_cnt, sp_cnt, expn);
                end
            end
        end
    end

    function automatic rec_t mk(input logic [6:0] f, input logic b, input int c);
        rec_t r;
        r.fld = f;
        r.b   = b;
        r.cnt = 4'(c);
        return r;
    endfunction

    // Reference frame model: field order and bit order of a CAN base frame.
    task automatic build(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                         input logic [63:0] data, input logic [14:0] crc,
                         input int stall_idx, input int limit, output int n);
        rec_t tmp[$];
        int   nb;
        tmp.push_back(mk(F_SOF, 1'b0, 0));
        for (int i = 10; i >= 0; i--) tmp.push_back(mk(F_ID, id[i], 0));
        tmp.push_back(mk(F_RTR, rtr, 0));
        tmp.push_back(mk(F_CTRL, 1'b0, 0));
        tmp.push_back(mk(F_CTRL, 1'b0, 0));
        for (int i = 3; i >= 0; i--) tmp.push_back(mk(F_CTRL, dlc[i], 0));
        nb = rtr ? 0 : ((int'(dlc) > 8 ? 8 : int'(dlc)) * 8);
        for (int i = 0; i < nb; i++) tmp.push_back(mk(F_DATA, data[63-i], 0));
        for (int i = 0; i < 15; i++) tmp.push_back(mk(F_CRC, crc[14-i], i));
        for (int i = 0; i < 10; i++) tmp.push_back(mk(F_TAIL, 1'b1, 14));
        n = 0;
        for (int k = 0; k < tmp.size(); k++) begin
            if (k < limit) begin
                exp_q.push_back(tmp[k]);
                n++;
                if (k == stall_idx) begin
                    exp_q.push_back(tmp[k]);
                    n++;
                end
            end
        end
    endtask

    task automatic sp(input logic stuff);
        repeat (2) @(posedge clock);
        #1;
        sample_point       = 1'b1;
        stuff_bit_inserted = stuff;
        @(posedge clock);
        #1;
        sample_point       = 1'b0;
        stuff_bit_inserted = 1'b0;
    endtask

    // Drop enable across a sample point strobe; it must be ignored.
    task automatic freeze_en();
        enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        sample_point = 1'b1;
        @(posedge clock);
        #1;
        sample_point = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        enable = 1'b1;
    endtask

    task automatic request_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                                 input logic [63:0] data);
        int cyc;
        tx_id      = id;
        tx_rtr     = rtr;
        tx_dlc     = dlc;
        tx_data    = data;
        tx_request = 1'b1;
        cyc = 0;
        while (!tx_accept && cyc < 8) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        tests++;
        if (tx_accept !== 1'b1 || sof_transmitting !== 1'b1) begin
            fails++;
            $display("FAIL accept: got tx_accept=%b sof=%b, required 1 1", tx_accept, sof_transmitting);
        end
    endtask

    task automatic check_reset(input string name);
        logic [19:0] got;
        got = {tx_accept, tx_busy, tx_done, sof_transmitting, sof_bit, id_complete, bit_id,
               rtr_complete, rtr_bit, control_complete, control_bit, data_complete, data_bit,
               crc_complete, crc_bit, crc_bit_counter, eof_complete};
        tests++;
        if (got !== 20'b00000_10_10_10_10_10_0000_0) begin
            fails++;
            $display("FAIL %s: got outputs %b, required %b", name, got, 20'b00000_10_10_10_10_10_0000_0);
        end
    endtask

    task automatic run_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data, input logic [14:0] crc,
                             input int stall_idx, input int freeze_idx,
                             input logic keep, input logic accepted);
        int n;
        int dc;
        int cyc;
        crc_value = crc;
        build(id, rtr, dlc, data, crc, stall_idx, 1000, n);
        done_q.push_back(n);
        if (!accepted) request_frame(id, rtr, dlc, data);
        tx_request = keep;
        dc = done_cnt;
        for (int k = 0; k < n; k++) begin
            if (k == freeze_idx) freeze_en();
            sp(k == stall_idx);
        end
        @(negedge clock);
        #1;
        tests++;
        if (done_cnt != dc + 1) begin
            fails++;
            $display("FAIL done_pulse: got %0d tx_done events, required 1", done_cnt - dc);
        end
        @(posedge clock);
        #1;
        tests++;
        if (tx_done !== 1'b0) begin
            fails++;
            $display("FAIL done_1cyc: got tx_done=%b one cycle later, required 0", tx_done);
        end
        if (keep) begin
            cyc = 1;
            while (!tx_accept && cyc < 8) begin
                @(posedge clock);
                #1;
                cyc++;
            end
            tests++;
            if (cyc != 2 || tx_accept !== 1'b1) begin
                fails++;
                $display("FAIL b2b_gap: got accept %0d cycles after DONE, required 2", cyc);
            end
        end
    endtask

    task automatic run_abort();
        int n;
        crc_value = 15'h1111;
        build(11'h123, 1'b0, 4'd2, 64'hC3C3_0000_0000_0000, 15'h1111, -1, 22, n);
        request_frame(11'h123, 1'b0, 4'd2, 64'hC3C3_0000_0000_0000);
        tx_request = 1'b0;
        for (int k = 0; k < n; k++) sp(1'b0);
        tests++;
        if (data_complete !== 1'b0) begin
            fails++;
            $display("FAIL abort_in_data: got data_complete=%b, required 0", data_complete);
        end
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_reset("abort_reset");
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL abort_q: got %0d unconsumed records, required 0", exp_q.size());
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset("abort_idle");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test by 400 us, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_reset("reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        // Data frame, all-ones ID, one 0xFF byte; held request chains a second copy.
        run_frame(11'h7FF, 1'b0, 4'd1, 64'hFF00_0000_0000_0000, 15'h1234, -1, -1, 1'b1, 1'b0);
        run_frame(11'h7FF, 1'b0, 4'd1, 64'hFF00_0000_0000_0000, 15'h1234, -1, -1, 1'b0, 1'b1);
        // Remote frame with DLC 8, enable dropped mid-CRC.
        run_frame(11'h2AA, 1'b1, 4'd8, 64'hDEAD_BEEF_0000_0000, 15'h7001, -1, 30, 1'b0, 1'b0);
        // Stuff stall on the 6th ID bit.
        run_frame(11'h5A3, 1'b0, 4'd2, 64'h3C5A_0000_0000_0000, 15'h0F0F, 6, -1, 1'b0, 1'b0);
        // DLC 12 clamps to 64 data bits; CRC 0x4A3C.
        run_frame(11'h0F0, 1'b0, 4'd12, 64'hA5A5_A5A5_A5A5_A5A5, 15'h4A3C, -1, -1, 1'b0, 1'b0);
        run_abort();
        run_frame(11'h001, 1'b0, 4'd0, 64'h0, 15'h7FFF, -1, -1, 1'b0, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        tests++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d records and %0d frames pending, required 0 0",
                     exp_q.size(), done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
